// File: rtl/trigger_crossbar_matrix.sv
// Trigger crossbar: synchronises NUM_IN asynchronous triggers and routes them to NUM_OUT
// registered outputs with per-output level/pulse/toggle modes, LED stretchers and a config port.
module trigger_crossbar_matrix #(
    parameter int NUM_IN      = 12,
    parameter int NUM_OUT     = 14,
    parameter int SEL_WIDTH   = $clog2(NUM_IN),
    parameter int LED_STRETCH = 12500000,
    parameter int PULSE_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IN-1:0]  trig_in,
    output logic [NUM_OUT-1:0] trig_out,
    output logic [NUM_IN-1:0]  trig_in_led,
    output logic [NUM_OUT-1:0] trig_out_led,
    input  logic               cfg_wr,
    input  logic               cfg_rd,
    input  logic [7:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               cfg_rd_valid
);
    localparam int LED_W = $clog2(LED_STRETCH + 1);
    localparam logic [LED_W-1:0] LED_LOAD = LED_W'(LED_STRETCH);

    typedef enum logic [1:0] {
        MODE_LEVEL    = 2'd0,
        MODE_PULSE    = 2'd1,
        MODE_TOGGLE   = 2'd2,
        MODE_DISABLED = 2'd3
    } mode_t;

    // Reload on activity, otherwise count down and stick at zero.
    function automatic logic [LED_W-1:0] led_next(input logic changed, input logic [LED_W-1:0] cnt);
        if (changed) return LED_LOAD;
        return (cnt == '0) ? '0 : cnt - LED_W'(1);
    endfunction

    function automatic logic [PULSE_WIDTH-1:0] pulse_len(input logic [PULSE_WIDTH-1:0] len);
        return (len == '0) ? PULSE_WIDTH'(1) : len;
    endfunction

    // Out-of-range selects read as 0, inversion does not apply to them.
    function automatic logic select_bit(input logic [NUM_IN-1:0] vec, input logic [SEL_WIDTH-1:0] sel,
                                        input logic inv);
        if (int'(sel) >= NUM_IN) return 1'b0;
        return vec[sel] ^ inv;
    endfunction

    logic [NUM_IN-1:0]      sync_p0, sync_p1, in_prev_p2;
    logic [SEL_WIDTH-1:0]   sel_r   [NUM_OUT];
    logic [NUM_OUT-1:0]     inv_r;
    mode_t                  mode_r  [NUM_OUT];
    logic [PULSE_WIDTH-1:0] len_r   [NUM_OUT];
    logic [PULSE_WIDTH-1:0] cnt_p3  [NUM_OUT];
    logic [NUM_OUT-1:0]     sel_sig, wr_hit, s_prev_p2, rise_p2, out_prev_p4;
    logic                   s_new;
    logic [31:0]            rd_word;
    logic [LED_W-1:0]       in_led_cnt  [NUM_IN];
    logic [LED_W-1:0]       out_led_cnt [NUM_OUT];
    logic                   unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    always_comb begin
        s_new   = select_bit(sync_p1, cfg_wdata[SEL_WIDTH-1:0], cfg_wdata[8]);
        sel_sig = '0;
        wr_hit  = '0;
        rd_word = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            sel_sig[k] = select_bit(sync_p1, sel_r[k], inv_r[k]);
            wr_hit[k]  = cfg_wr && (cfg_addr == 8'(k));
            if (cfg_addr == 8'(k)) begin
                rd_word[SEL_WIDTH-1:0]        = sel_r[k];
                rd_word[8]                    = inv_r[k];
                rd_word[10:9]                 = mode_r[k];
                rd_word[16 +: PULSE_WIDTH]    = len_r[k];
            end
        end
    end

    // p0/p1: two-flop synchroniser; p2: previous synchronised value for activity detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0    <= '0;
            sync_p1    <= '0;
            in_prev_p2 <= '0;
        end else begin
            sync_p0    <= trig_in;
            sync_p1    <= sync_p0;
            in_prev_p2 <= sync_p1;
        end
    end

    // p2: per-output edge stage; p3: mode logic and registered output.
    // A write reloads the edge stage with the new selection so reconfiguring never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_r     <= '0;
            s_prev_p2 <= '0;
            rise_p2   <= '0;
            trig_out  <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                sel_r[k]  <= '0;
                mode_r[k] <= MODE_DISABLED;
                len_r[k]  <= '0;
                cnt_p3[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (wr_hit[k]) begin
                    sel_r[k]     <= cfg_wdata[SEL_WIDTH-1:0];
                    inv_r[k]     <= cfg_wdata[8];
                    mode_r[k]    <= mode_t'(cfg_wdata[10:9]);
                    len_r[k]     <= cfg_wdata[16 +: PULSE_WIDTH];
                    s_prev_p2[k] <= s_new;
                    rise_p2[k]   <= 1'b0;
                    cnt_p3[k]    <= '0;
                    trig_out[k]  <= 1'b0;
                end else begin
                    s_prev_p2[k] <= sel_sig[k];
                    rise_p2[k]   <= sel_sig[k] & ~s_prev_p2[k];
                    case (mode_r[k])
                        MODE_LEVEL: begin
                            cnt_p3[k]   <= '0;
                            trig_out[k] <= s_prev_p2[k];
                        end
                        MODE_PULSE: begin
                            if (cnt_p3[k] == '0) begin
                                if (rise_p2[k]) begin
                                    cnt_p3[k]   <= pulse_len(len_r[k]);
                                    trig_out[k] <= 1'b1;
                                end else begin
                                    trig_out[k] <= 1'b0;
                                end
                            end else begin
                                cnt_p3[k]   <= cnt_p3[k] - PULSE_WIDTH'(1);
                                trig_out[k] <= (cnt_p3[k] != PULSE_WIDTH'(1));
                            end
                        end
                        MODE_TOGGLE: begin
                            if (rise_p2[k]) trig_out[k] <= ~trig_out[k];
                        end
                        default: begin
                            cnt_p3[k]   <= '0;
                            trig_out[k] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // p4: previous output value and LED stretch counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_prev_p4 <= '0;
            for (int i = 0; i < NUM_IN; i++) in_led_cnt[i] <= '0;
            for (int k = 0; k < NUM_OUT; k++) out_led_cnt[k] <= '0;
        end else begin
            out_prev_p4 <= trig_out;
            for (int i = 0; i < NUM_IN; i++)
                in_led_cnt[i] <= led_next(sync_p1[i] ^ in_prev_p2[i], in_led_cnt[i]);
            for (int k = 0; k < NUM_OUT; k++)
                out_led_cnt[k] <= led_next(trig_out[k] ^ out_prev_p4[k], out_led_cnt[k]);
        end
    end

    always_comb begin
        trig_in_led  = '0;
        trig_out_led = '0;
        for (int i = 0; i < NUM_IN; i++) trig_in_led[i] = (in_led_cnt[i] != '0);
        for (int k = 0; k < NUM_OUT; k++) trig_out_led[k] = (out_led_cnt[k] != '0);
    end

    // Read data samples the pre-write register contents, so a same-cycle write returns the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_rdata    <= '0;
            cfg_rd_valid <= 1'b0;
        end else begin
            cfg_rd_valid <= cfg_rd;
            if (cfg_rd) cfg_rdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_trigger_crossbar_matrix.sv
// Bench for trigger_crossbar_matrix: directed steps plus random traffic, checked every cycle
// against a history-based reference model.
module tb_trigger_crossbar_matrix;
    localparam int NUM_IN  = 12;
    localparam int NUM_OUT = 14;
    localparam int LS      = 20;
    localparam int HMAX    = 4096;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_IN-1:0]  trig_in = '0;
    logic [NUM_OUT-1:0] trig_out;
    logic [NUM_IN-1:0]  trig_in_led;
    logic [NUM_OUT-1:0] trig_out_led;
    logic               cfg_wr = 1'b0;
    logic               cfg_rd = 1'b0;
    logic [7:0]         cfg_addr = '0;
    logic [31:0]        cfg_wdata = '0;
    logic [31:0]        cfg_rdata;
    logic               cfg_rd_valid;

    trigger_crossbar_matrix #(
        .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .SEL_WIDTH(4), .LED_STRETCH(LS), .PULSE_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .trig_out(trig_out),
        .trig_in_led(trig_in_led), .trig_out_led(trig_out_led),
        .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .cfg_rd_valid(cfg_rd_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Model: input/output history indexed by clock edge, plus per-output config and event times.
    logic [NUM_IN-1:0]  in_hist  [0:HMAX-1];
    logic [NUM_OUT-1:0] out_hist [0:HMAX-1];
    int  m_sel [NUM_OUT];
    bit  m_inv [NUM_OUT];
    int  m_mode[NUM_OUT];
    int  m_len [NUM_OUT];
    int  m_w   [NUM_OUT];
    int  m_pend[NUM_OUT];
    bit  m_tog [NUM_OUT];
    int  in_until [NUM_IN];
    int  out_until[NUM_OUT];
    logic [NUM_OUT-1:0] exp_out = '0;
    logic [NUM_IN-1:0]  exp_in_led = '0;
    logic [NUM_OUT-1:0] exp_out_led = '0;
    logic               exp_rvalid = 1'b0;
    logic [31:0]        exp_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit s_of(int k, int c);
        if (m_sel[k] >= NUM_IN) return 1'b0;
        return in_hist[c][m_sel[k]] ^ m_inv[k];
    endfunction

    function automatic logic [31:0] enc(int k);
        logic [31:0] w;
        w = '0;
        w[3:0]   = 4'(m_sel[k]);
        w[8]     = m_inv[k];
        w[10:9]  = 2'(m_mode[k]);
        w[31:16] = 16'(m_len[k]);
        return w;
    endfunction

    // Level follows the selection 3 edges after the input is sampled; a rising edge seen there
    // starts a pulse (if none is running) or flips the toggle state. A write zeroes the output.
    task automatic model_edge();
        logic [NUM_OUT-1:0] o;
        bit rise;
        int k;
        in_hist[n] = trig_in;
        exp_rvalid = cfg_rd;
        if (cfg_rd) exp_rdata = (cfg_addr < NUM_OUT) ? enc(int'(cfg_addr)) : 32'h0;
        if (cfg_wr && cfg_addr < NUM_OUT) begin
            k = int'(cfg_addr);
            m_sel[k]  = int'(cfg_wdata[3:0]);
            m_inv[k]  = cfg_wdata[8];
            m_mode[k] = int'(cfg_wdata[10:9]);
            m_len[k]  = int'(cfg_wdata[31:16]);
            m_w[k]    = n;
            m_pend[k] = n;
            m_tog[k]  = 1'b0;
        end
        o = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            rise = (n >= m_w[j] + 2) && s_of(j, n - 3) && !s_of(j, n - 4);
            if (n == m_w[j]) o[j] = 1'b0;
            else case (m_mode[j])
                0: o[j] = s_of(j, n - 3);
                1: begin
                    if (rise && n > m_pend[j]) m_pend[j] = n + ((m_len[j] == 0) ? 1 : m_len[j]);
                    o[j] = (n < m_pend[j]);
                end
                2: begin
                    if (rise) m_tog[j] = ~m_tog[j];
                    o[j] = m_tog[j];
                end
                default: o[j] = 1'b0;
            endcase
        end
        out_hist[n] = o;
        exp_out = o;
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_hist[n-2][i] != in_hist[n-3][i]) in_until[i] = n + LS;
            exp_in_led[i] = (n < in_until[i]);
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            if (out_hist[n-1][j] != out_hist[n-2][j]) out_until[j] = n + LS;
            exp_out_led[j] = (n < out_until[j]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        if (n >= HMAX) begin
            $display("FAIL history_overflow observed %0d required < %0d", n, HMAX);
            $fatal(1, "history exhausted");
        end
        model_edge();
        @(negedge clk);
        chk("trig_out", 32'(trig_out), 32'(exp_out));
        chk("trig_in_led", 32'(trig_in_led), 32'(exp_in_led));
        chk("trig_out_led", 32'(trig_out_led), 32'(exp_out_led));
        chk("rd_valid", 32'(cfg_rd_valid), 32'(exp_rvalid));
        if (exp_rvalid) chk("rd_data", cfg_rdata, exp_rdata);
    endtask

    task automatic ticks(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cfg_addr = a; cfg_wdata = d; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        cfg_addr = a; cfg_rd = 1'b1;
        tick();
        cfg_rd = 1'b0;
    endtask

    initial begin
        int hi;
        for (int i = 0; i < HMAX; i++) begin in_hist[i] = '0; out_hist[i] = '0; end
        for (int k = 0; k < NUM_OUT; k++) begin
            m_sel[k] = 0; m_inv[k] = 0; m_mode[k] = 3; m_len[k] = 0;
            m_w[k] = 0; m_pend[k] = 0; m_tog[k] = 0; out_until[k] = 0;
        end
        for (int i = 0; i < NUM_IN; i++) in_until[i] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 8;
        chk("reset_trig_out", 32'(trig_out), 32'h0);
        chk("reset_in_led", 32'(trig_in_led), 32'h0);
        chk("reset_out_led", 32'(trig_out_led), 32'h0);
        rd(8'd0);
        chk("reset_read0", cfg_rdata, 32'h0000_0600);

        // LEVEL on output 2 from input 5, then inversion and out-of-range select
        wr(8'd2, 32'h0000_0005);
        ticks(6);
        trig_in[5] = 1'b1;
        ticks(3);
        chk("level_lat3", 32'(trig_out[2]), 32'h0);
        tick();
        chk("level_lat4", 32'(trig_out[2]), 32'h1);
        wr(8'd2, 32'h0000_0105);
        ticks(6);
        chk("level_inv", 32'(trig_out[2]), 32'h0);
        wr(8'd2, 32'h0000_010D);
        ticks(6);
        chk("sel13_inv", 32'(trig_out[2]), 32'h0);
        wr(8'd2, 32'h0000_000D);
        ticks(6);
        chk("sel13", 32'(trig_out[2]), 32'h0);

        // PULSE len 10 with an ignored retrigger, then len 0
        wr(8'd0, 32'h000A_0201);
        ticks(6);
        hi = 0;
        for (int t = 0; t < 25; t++) begin
            trig_in[1] = (t < 2) || (t >= 5 && t < 7);
            tick();
            hi += int'(trig_out[0]);
        end
        chk("pulse_len10", 32'(hi), 32'd10);
        wr(8'd0, 32'h0000_0201);
        ticks(4);
        hi = 0;
        for (int t = 0; t < 15; t++) begin
            trig_in[1] = (t < 2);
            tick();
            hi += int'(trig_out[0]);
        end
        chk("pulse_len0", 32'(hi), 32'd1);

        // TOGGLE on output 3 from input 2
        wr(8'd3, 32'h0000_0402);
        ticks(6);
        for (int e = 0; e < 3; e++) begin
            trig_in[2] = 1'b1; ticks(3);
            trig_in[2] = 1'b0; ticks(3);
            chk("toggle_seq", 32'(trig_out[3]), (e == 1) ? 32'h0 : 32'h1);
        end
        trig_in[2] = 1'b1;
        ticks(5);
        wr(8'd3, 32'h0000_0402);
        ticks(8);
        chk("toggle_rewrite", 32'(trig_out[3]), 32'h0);

        // LED stretch on input 7
        ticks(30);
        hi = 0;
        trig_in[7] = 1'b1;
        for (int t = 0; t < 40; t++) begin tick(); hi += int'(trig_in_led[7]); end
        chk("led_single", 32'(hi), 32'd20);
        hi = 0;
        for (int t = 0; t < 60; t++) begin
            if (t == 0) trig_in[7] = 1'b0;
            if (t == 15) trig_in[7] = 1'b1;
            tick();
            hi += int'(trig_in_led[7]);
        end
        chk("led_restretch", 32'(hi), 32'd35);

        // Config write coinciding with the selected edge discards that edge
        wr(8'd4, 32'h0005_0209);
        ticks(6);
        trig_in[9] = 1'b1;
        ticks(2);
        wr(8'd4, 32'h0005_0209);
        hi = 0;
        for (int t = 0; t < 12; t++) begin tick(); hi += int'(trig_out[4]); end
        chk("wr_edge_collide", 32'(hi), 32'd0);

        // Out-of-range access, and read-back of an earlier write
        wr(8'd20, 32'h0000_0205);
        rd(8'd20);
        chk("oor_read_data", cfg_rdata, 32'h0);
        chk("oor_read_valid", 32'(cfg_rd_valid), 32'h1);
        rd(8'd2);
        chk("read_back2", cfg_rdata, 32'h0000_000D);

        // Random traffic against the model
        for (int t = 0; t < 400; t++) begin
            if (t % 3 == 0) trig_in = NUM_IN'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                cfg_addr  = 8'($urandom_range(0, 15));
                cfg_wdata = $urandom;
                cfg_wdata[31:16] = 16'($urandom_range(0, 7));
                cfg_wr = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) cfg_rd = 1'b1;
            tick();
            cfg_wr = 1'b0;
            cfg_rd = 1'b0;
        end

        // Asynchronous reset during an active pulse
        trig_in = '0;
        ticks(6);
        wr(8'd0, 32'h0032_0201);
        ticks(3);
        trig_in[1] = 1'b1;
        ticks(6);
        chk("pulse_active", 32'(trig_out[0]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", 32'(trig_out), 32'h0);
        chk("async_reset_in_led", 32'(trig_in_led), 32'h0);
        chk("async_reset_valid", 32'(cfg_rd_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
